// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// UART_RX_PARITY_EN adds the parity state to the receiver FSM.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } rx_state_e;

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with level count; a push while full is dropped
// unless a pop happens on the same edge.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [WIDTH-1:0]              wdata_i,
    output logic [WIDTH-1:0]              rdata_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [level_width(DEPTH)-1:0] level_o,
    output logic                          drop_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = level_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        empty_o  = (level_q == '0);
        full_o   = (level_q == LvlW'(DEPTH));
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        drop_o   = push_i && !do_push;
        wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LvlW'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LvlW'(1);
        end
        // Storage is not reset, so the head is masked while empty.
        rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q];
        level_o  = level_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampled 8N1) feeding a show-ahead byte FIFO with sticky errors.
// Define UART_RX_PARITY_EN for 8E1/8O1 frames with parity_odd/parity_err ports.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          rx,
    input  logic                          rx_en,
    input  logic [15:0]                   baud_div,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rx_empty,
    output logic                          rx_full,
    output logic [level_width(DEPTH)-1:0] rx_level,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr,
`ifdef UART_RX_PARITY_EN
    input  logic                          parity_odd,
    output logic                          parity_err,
`endif
    output logic                          irq
);

    localparam int unsigned BitIdxW = $clog2(DATA_BITS);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    rx_state_e              state_q, state_d;
    logic [15:0]            presc_q, presc_d;
    logic [3:0]             samp_q, samp_d;
    logic [BitIdxW-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic                   rs, tick, samp_last, push, frame_set, drop;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err_q, parity_err_d, par_set;
`endif

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
        rs        = sync_q[SYNC_STAGES-1];
        tick      = (presc_q == baud_div);
        samp_last = tick && (samp_q == 4'(OVERSAMPLE - 1));
        state_d   = state_q;
        presc_d   = tick ? '0 : presc_q + 16'd1;
        samp_d    = tick ? samp_q + 4'd1 : samp_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (rx_en && !rs) begin
                    state_d = StStart;
                    presc_d = '0;
                    samp_d  = '0;
                end
            end
            StStart: begin
                if (tick && samp_q == 4'(MID_SAMPLE)) begin
                    state_d = rs ? StIdle : StData;
                    samp_d  = '0;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (samp_last) begin
                    shreg_d = {rs, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BitIdxW'(1);
                    if (bit_q == BitIdxW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (samp_last) begin
                    par_set = (rs != (^shreg_q ^ parity_odd));
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (samp_last) begin
                    push      = rs;
                    frame_set = !rs;
                    state_d   = rs ? StIdle : StBreak;
                end
            end
            StBreak: begin
                if (rs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Disabling the receiver abandons any frame in flight, including its final sample.
        if (!rx_en) begin
            state_d   = StIdle;
            push      = 1'b0;
            frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_set   = 1'b0;
`endif
        end
        // Clear wins over a same-cycle set.
        frame_err_d = err_clr ? 1'b0 : (frame_err_q | frame_set);
        overrun_d   = err_clr ? 1'b0 : (overrun_q | drop);
`ifdef UART_RX_PARITY_EN
        parity_err_d = err_clr ? 1'b0 : (parity_err_q | par_set);
`endif
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync_q      <= '1;
            state_q     <= StIdle;
            presc_q     <= '0;
            samp_q      <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            presc_q     <= presc_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
`endif

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i   (HCLK),
        .rst_i   (HRESET),
        .push_i  (push),
        .pop_i   (rd_en),
        .wdata_i (shreg_q),
        .rdata_o (rd_data),
        .empty_o (rx_empty),
        .full_o  (rx_full),
        .level_o (rx_level),
        .drop_o  (drop)
    );

    always_comb begin
        frame_err = frame_err_q;
        overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
        parity_err = parity_err_q;
        irq        = !rx_empty | frame_err_q | overrun_q | parity_err_q;
`else
        irq        = !rx_empty | frame_err_q | overrun_q;
`endif
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: scoreboarded byte stream at baud_div=9.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_EDGE = 1523 + 160;
`else
    localparam int STOP_EDGE = 1523;
`endif

    logic          HCLK = 1'b0, HRESET = 1'b1, rx = 1'b1, rx_en = 1'b1;
    logic          rd_en = 1'b0, err_clr = 1'b0;
    logic [15:0]   baud_div = 16'd9;
    logic [7:0]    rd_data;
    logic          rx_empty, rx_full, frame_err, overrun, irq;
    logic [LW-1:0] rx_level;
`ifdef UART_RX_PARITY_EN
    logic          parity_odd = 1'b0, parity_err;
    logic          bad_par = 1'b0;
`endif

    int         n_cmp = 0, n_bad = 0;
    int         edge_cnt = 0, pop_at = -1;
    logic [7:0] exp_q[$];

    always #5 HCLK = ~HCLK;

    uart_rx_fifo #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .rx         (rx),
        .rx_en      (rx_en),
        .baud_div   (baud_div),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .rx_level   (rx_level),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
        .parity_err (parity_err),
`endif
        .irq        (irq)
    );

    // Holds rx at v for len edges; optionally pops the head in the stop-sample cycle.
    task automatic drive_bit(input logic v, input int len);
        logic [7:0] e;
        rx = v;
        for (int i = 0; i < len; i++) begin
            @(posedge HCLK);
            edge_cnt++;
            #1;
            if (edge_cnt + 1 == pop_at) begin
                e = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
                n_cmp++;
                if (rx_empty !== 1'b0 || rd_data !== e) begin
                    n_bad++;
                    $display("FAIL pop_at_stop: rd_data=%h empty=%b, expected %h", rd_data,
                             rx_empty, e);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
        end
    endtask

    task automatic send_head(input logic [7:0] d);
        edge_cnt = 0;
        drive_bit(1'b0, 160);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 160);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d ^ parity_odd ^ bad_par, 160);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pop);
        if (exp_q.size() < DEPTH || pop) exp_q.push_back(d);
        if (pop) pop_at = STOP_EDGE;
        send_head(d);
        drive_bit(1'b1, 160);
        pop_at = -1;
    endtask

    task automatic drain(input int n);
        int         w;
        logic [7:0] e;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (rx_empty && w < 3000) begin
                @(posedge HCLK);
                #1;
                w++;
            end
            e = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
            n_cmp++;
            if (rx_empty !== 1'b0 || rd_data !== e) begin
                n_bad++;
                $display("FAIL drain[%0d]: rd_data=%h empty=%b, expected %h", k, rd_data,
                         rx_empty, e);
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            rd_en = 1'b1;
            @(posedge HCLK);
            #1;
            rd_en = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge HCLK);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        n_cmp++;
        if ({rd_data, rx_empty, rx_full, frame_err, overrun, irq} !== {8'h00, 5'b10000}) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b%b, expected 00/10000", rd_data,
                     rx_empty, rx_full, frame_err, overrun, irq);
        end
        n_cmp++;
        if (rx_level !== '0) begin
            n_bad++;
            $display("FAIL reset_level: got %0d, expected 0", rx_level);
        end
        drive_bit(1'b1, 20);
    endtask

    task automatic test_single();
        send_head(8'hA5);
        drive_bit(1'b1, 82);
        n_cmp++;
        if (rx_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL single_early: rx_empty=%b, expected 1", rx_empty);
        end
        drive_bit(1'b1, 1);
        n_cmp++;
        if ({rx_empty, rd_data, irq} !== {1'b0, 8'hA5, 1'b1} || rx_level !== LW'(1)) begin
            n_bad++;
            $display("FAIL single_visible: empty=%b rd_data=%h irq=%b level=%0d, expected 0 a5 1 1",
                     rx_empty, rd_data, irq, rx_level);
        end
        drive_bit(1'b1, 77);
        exp_q.push_back(8'hA5);
        drain(1);
        n_cmp++;
        if ({rx_empty, irq} !== 2'b10) begin
            n_bad++;
            $display("FAIL single_popped: empty=%b irq=%b, expected 1 0", rx_empty, irq);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b1, 100);
        n_cmp++;
        if (rx_level !== LW'(3) || frame_err !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_level: level=%0d ferr=%b ovr=%b, expected 3 0 0", rx_level,
                     frame_err, overrun);
        end
        drain(3);
    endtask

    task automatic test_glitch();
        edge_cnt = 0;
        drive_bit(1'b0, 60);
        drive_bit(1'b1, 300);
        n_cmp++;
        if ({rx_empty, frame_err, irq} !== 3'b100) begin
            n_bad++;
            $display("FAIL glitch: empty=%b ferr=%b irq=%b, expected 1 0 0", rx_empty, frame_err,
                     irq);
        end
        send_frame(8'h5A, 1'b0);
        drain(1);
    endtask

    task automatic test_frame_err();
        send_head(8'h55);
        drive_bit(1'b0, 400);
        drive_bit(1'b1, 200);
        n_cmp++;
        if ({frame_err, rx_empty, irq} !== 3'b111) begin
            n_bad++;
            $display("FAIL frame_err_set: ferr=%b empty=%b irq=%b, expected 1 1 1", frame_err,
                     rx_empty, irq);
        end
        send_frame(8'h12, 1'b0);
        drain(1);
        n_cmp++;
        if (frame_err !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_err_sticky: ferr=%b, expected 1", frame_err);
        end
        pulse_clr();
        n_cmp++;
        if ({frame_err, irq} !== 2'b00) begin
            n_bad++;
            $display("FAIL frame_err_clr: ferr=%b irq=%b, expected 0 0", frame_err, irq);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i * 7 + 1), 1'b0);
        n_cmp++;
        if ({rx_full, overrun} !== 2'b11 || rx_level !== LW'(DEPTH)) begin
            n_bad++;
            $display("FAIL overrun_set: full=%b ovr=%b level=%0d, expected 1 1 %0d", rx_full,
                     overrun, rx_level, DEPTH);
        end
        pulse_clr();
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_clr: ovr=%b, expected 0", overrun);
        end
        send_frame(8'hC3, 1'b1);
        n_cmp++;
        if ({rx_full, overrun} !== 2'b10 || rx_level !== LW'(DEPTH)) begin
            n_bad++;
            $display("FAIL push_pop_full: full=%b ovr=%b level=%0d, expected 1 0 %0d", rx_full,
                     overrun, rx_level, DEPTH);
        end
        drain(DEPTH);
        n_cmp++;
        if (rx_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_drained: empty=%b, expected 1", rx_empty);
        end
    endtask

    // Aborts an 0xF0 frame in the middle of data bit 4 by reset (use_reset) or rx_en.
    task automatic test_abort(input bit use_reset);
        edge_cnt = 0;
        drive_bit(1'b0, 160);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 160);
        drive_bit(1'b1, 80);
        if (use_reset) HRESET = 1'b1;
        else rx_en = 1'b0;
        drive_bit(1'b1, 1);
        HRESET = 1'b0;
        rx_en  = 1'b1;
        drive_bit(1'b1, 79 + 160 * 6);
        n_cmp++;
        if ({rx_empty, frame_err, irq} !== 3'b100 || rx_level !== '0) begin
            n_bad++;
            $display("FAIL abort_%0d: empty=%b ferr=%b irq=%b level=%0d, expected 1 0 0 0",
                     use_reset, rx_empty, frame_err, irq, rx_level);
        end
        send_frame(8'h81, 1'b0);
        drain(1);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        parity_odd = 1'b0;
        bad_par    = 1'b1;
        send_frame(8'h81, 1'b0);
        bad_par    = 1'b0;
        n_cmp++;
        if ({parity_err, irq} !== 2'b11) begin
            n_bad++;
            $display("FAIL parity_set: perr=%b irq=%b, expected 1 1", parity_err, irq);
        end
        drain(1);
        pulse_clr();
        n_cmp++;
        if ({parity_err, irq} !== 2'b00) begin
            n_bad++;
            $display("FAIL parity_clr: perr=%b irq=%b, expected 0 0", parity_err, irq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_abort(1'b1);
        test_abort(1'b0);
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver peripheral core for the Hazard2 SoC. Pairs with the SoC's UART_TX so the core can accept serial input from the test terminal or host. Details:
- Deserialises 8N1 frames (optionally 8E1/8O1) using 16x oversampling.
- Buffers received bytes in a show-ahead FIFO.
- Exposes sticky error flags.
- Sits behind an AHB-Lite register wrapper; that wrapper is out of scope.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, 2..256
SYNC_STAGES, 2, rx input synchroniser flops; minimum 2

Ports:
HCLK  input  1  system clock, rising edge
HRESET  input  1  synchronous reset, active-high
rx  input  1  serial line, idle high, asynchronous to HCLK
rx_en  input  1  receiver enable
baud_div  input  16  oversample prescaler; tick every baud_div+1 HCLK cycles
rd_en  input  1  pop FIFO head
rd_data  output  8  FIFO head byte, valid when rx_empty=0
rx_empty  output  1  FIFO empty
rx_full  output  1  FIFO full
rx_level  output  $clog2(DEPTH)+1  bytes held in FIFO
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte dropped because FIFO full
err_clr  input  1  clears frame_err and overrun
irq  output  1  (!rx_empty) | frame_err | overrun

Behaviour:
- Reset (HRESET=1 at a HCLK edge) sets:
  - state IDLE, prescaler 0, FIFO pointers 0
  - rd_data=0, rx_empty=1, rx_full=0, rx_level=0, frame_err=0, overrun=0, irq=0
  - synchroniser flops to 1
- Reset mid-frame aborts the frame. The partial byte is never pushed.
- rx passes through SYNC_STAGES flops. All decisions use the synchronised value rs.
- Prescaler:
  - Counts 0..baud_div, then wraps to 0.
  - tick=1 for one cycle when count==baud_div.
  - With baud_div=0, tick is asserted every cycle.
  - Bit period = 16*(baud_div+1) HCLK cycles.
  - Prescaler and sample counter (4-bit) are zeroed on the IDLE->START transition.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP, BREAK.
  - IDLE: if rx_en & rs==0 -> START.
  - START: on the tick where the sample count reaches 7 (mid start bit):
    - rs==0: -> DATA, sample count=0, bit index=0.
    - rs==1: glitch; -> IDLE with no flag.
  - DATA: on every 16th tick, sample rs and shift it in at bit 7 (LSB-first line order). After bit index 7 -> STOP, or -> PARITY when the feature is enabled.
  - STOP: on the 16th tick, sample rs.
    - rs==1: push the byte and -> IDLE.
    - rs==0: set frame_err, discard the byte, -> BREAK.
  - BREAK: wait for rs==1, then -> IDLE.
- rx_en=0 forces the FSM to IDLE on the next edge from any state, discarding the partial frame. The FIFO is unaffected.
- FIFO push and read:
  - A pushed byte is visible one cycle after the stop-sample edge: rx_empty falls and rd_data is valid.
  - rd_data is show-ahead. rd_en with rx_empty=0 advances the head on that edge.
  - rd_en while empty is ignored.
- Push while full:
  - Without a simultaneous pop: the byte is dropped and overrun is set.
  - With a simultaneous pop: both happen, no overrun, rx_level unchanged.
- Pointers wrap modulo DEPTH. rx_full = (rx_level==DEPTH).
- err_clr takes priority over a same-cycle set, so the flag clears. The event is lost, which is acceptable.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - Adds input parity_odd (1 bit) and sticky output parity_err.
  - PARITY state samples one bit on the 16th tick.
  - Mismatch against the even/odd parity of the 8 data bits sets parity_err; the byte is still pushed if the stop bit is valid.
  - err_clr also clears parity_err, and it is ORed into irq.
- Undefined: no PARITY state, no extra ports; the frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum
  - OVERSAMPLE=16 and MID_SAMPLE=7
  - DATA_BITS=8
  - level-width helper function
- One natural sub-module: sync_fifo. It takes DEPTH and WIDTH=8 and provides show-ahead read, push/pop, level and full/empty. It is reusable by a future TX FIFO.

Test Plan:
All scenarios use baud_div=9, so one bit = 160 HCLK cycles.
- Send 8N1 byte 0xA5 -> rd_data=0xA5, rx_level=1, irq=1 one cycle after stop sample. rd_en pulse -> rx_empty=1, irq=0.
- Send 0x00,0xFF,0x3C back-to-back (no idle gap) -> three bytes read in order, no errors.
- Pull rx low for 60 cycles, then high -> no byte, no flag, FSM back in IDLE.
- Send 0x55 with stop bit low, holding rx low 400 cycles -> frame_err=1, rx_empty stays 1. Next valid 0x12 is received correctly. err_clr -> frame_err=0.
- Send DEPTH+1 bytes without reading -> rx_full=1, overrun=1, first DEPTH bytes intact. Repeat with rd_en pulsed in the stop-sample cycle -> no overrun.
- Assert HRESET, or drop rx_en, at bit index 4 of a frame -> no push, state IDLE. The following frame 0x81 is received correctly. With UART_RX_PARITY_EN and parity_odd=0, send 0x81 with a wrong parity bit -> parity_err=1 and the byte is still pushed.
